// File: rtl/dcu_pkg.sv
// Shared definitions for the datapath check unit: check bit positions,
// the check-mask type and the expected condition-code helper.
package dcu_pkg;

  localparam int CHK_CONTENTION = 0;
  localparam int CHK_MISMATCH   = 1;
  localparam int CHK_FLAG       = 2;
  localparam int CHK_NZP_MULTI  = 3;
  localparam int NUM_CHK        = 4;

  // Callers sign-extend their bus to this width before asking for flags.
  localparam int NZP_MAX_W = 64;

  typedef logic [NUM_CHK-1:0] chk_mask_t;

  function automatic logic [2:0] nzp_of(input logic signed [NZP_MAX_W-1:0] value);
    if (value[NZP_MAX_W-1]) begin
      return 3'b100;
    end else if (value == '0) begin
      return 3'b010;
    end
    return 3'b001;
  endfunction

endpackage

// File: rtl/dcu_log_fifo.sv
// First-word-fall-through FIFO for the error log. The head is driven to zero
// while empty so nothing undefined ever reaches the ports.
module dcu_log_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              empty, do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  // A pop frees the slot this same edge, so a full FIFO still accepts a push.
  assign do_push = push_i && (!full_o || do_pop);

  assign valid_o = !empty;
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/datapath_check_unit.sv
// Datapath monitor: bus contention/mismatch and NZP flag checks, with sticky
// flags, a saturating count, first-error capture and a timestamped log.
module datapath_check_unit
  import dcu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_DRV   = 4,
  parameter int CNT_W     = 8,
  parameter int CYC_W     = 32,
  parameter int LOG_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         bus,
  input  logic [NUM_DRV-1:0]       drv_ena,
  input  logic [NUM_DRV*WIDTH-1:0] drv_data,
  input  logic                     flag_we,
  input  logic                     n,
  input  logic                     z,
  input  logic                     p,
  output logic [NUM_CHK-1:0]       err_sticky,
  output logic [CNT_W-1:0]         err_count,
  output logic                     first_valid,
  output logic [NUM_CHK-1:0]       first_mask,
  output logic [CYC_W-1:0]         first_cyc,
  output logic                     log_valid,
  input  logic                     log_ready,
  output logic [NUM_CHK-1:0]       log_mask,
  output logic [CYC_W-1:0]         log_cyc,
  output logic                     log_ovf
);

  localparam int PC_W  = $clog2(NUM_DRV + 1);
  localparam int LOG_W = NUM_CHK + CYC_W;

  logic [WIDTH-1:0] drv_word [NUM_DRV];
  logic [PC_W-1:0]  ena_cnt;
  logic [WIDTH-1:0] sel_data;
  chk_mask_t        raw_mask, mask;
  logic [2:0]       mask_pc;
  logic [CNT_W:0]   count_sum;

  logic [CYC_W-1:0] cyc_q;
  logic             exp_valid_q;
  logic [2:0]       exp_nzp_q;

  chk_mask_t        sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             first_valid_q, first_valid_d;
  chk_mask_t        first_mask_q, first_mask_d;
  logic [CYC_W-1:0] first_cyc_q, first_cyc_d;
  logic             ovf_q, ovf_d;

  logic             log_push, log_pop, log_full;
  logic [LOG_W-1:0] log_head;

  for (genvar gi = 0; gi < NUM_DRV; gi++) begin : g_drv
    assign drv_word[gi] = drv_data[gi*WIDTH +: WIDTH];
  end

  always_comb begin
    ena_cnt  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      ena_cnt = ena_cnt + PC_W'(drv_ena[i]);
      if (drv_ena[i]) sel_data = sel_data | drv_word[i];
    end
  end

  always_comb begin
    raw_mask                 = '0;
    raw_mask[CHK_CONTENTION] = (ena_cnt > PC_W'(1));
    raw_mask[CHK_MISMATCH]   = (ena_cnt == PC_W'(1)) && (bus != sel_data);
    raw_mask[CHK_FLAG]       = exp_valid_q && ({n, z, p} != exp_nzp_q);
    raw_mask[CHK_NZP_MULTI]  = (n & z) | (n & p) | (z & p);
    mask                     = enable ? raw_mask : '0;
  end

  always_comb begin
    mask_pc = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      mask_pc = mask_pc + 3'(mask[i]);
    end
  end

  assign count_sum = {1'b0, count_q} + {{(CNT_W-2){1'b0}}, mask_pc};

  always_comb begin
    sticky_d      = sticky_q;
    count_d       = count_q;
    first_valid_d = first_valid_q;
    first_mask_d  = first_mask_q;
    first_cyc_d   = first_cyc_q;
    ovf_d         = ovf_q;
    if (clear) begin
      sticky_d      = '0;
      count_d       = '0;
      first_valid_d = 1'b0;
      first_mask_d  = '0;
      first_cyc_d   = '0;
      ovf_d         = 1'b0;
    end else begin
      if (mask != '0) begin
        sticky_d = sticky_q | mask;
        count_d  = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
        if (!first_valid_q) begin
          first_valid_d = 1'b1;
          first_mask_d  = mask;
          first_cyc_d   = cyc_q;
        end
      end
      if (log_push && log_full && !log_pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q         <= '0;
      exp_valid_q   <= 1'b0;
      exp_nzp_q     <= '0;
      sticky_q      <= '0;
      count_q       <= '0;
      first_valid_q <= 1'b0;
      first_mask_q  <= '0;
      first_cyc_q   <= '0;
      ovf_q         <= 1'b0;
    end else begin
      cyc_q         <= cyc_q + CYC_W'(1);
      exp_valid_q   <= enable && flag_we;
      exp_nzp_q     <= nzp_of(NZP_MAX_W'(signed'(bus)));
      sticky_q      <= sticky_d;
      count_q       <= count_d;
      first_valid_q <= first_valid_d;
      first_mask_q  <= first_mask_d;
      first_cyc_q   <= first_cyc_d;
      ovf_q         <= ovf_d;
    end
  end

  // The log still records errors in a clearing cycle; clear only resets the summary state.
  assign log_push = (mask != '0);
  assign log_pop  = log_valid && log_ready;

  dcu_log_fifo #(
    .DATA_W(LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk        (clk),
    .rst        (rst),
    .push_i     (log_push),
    .push_data_i({mask, cyc_q}),
    .pop_i      (log_pop),
    .valid_o    (log_valid),
    .head_o     (log_head),
    .full_o     (log_full)
  );

  assign log_mask    = log_head[LOG_W-1 -: NUM_CHK];
  assign log_cyc     = log_head[CYC_W-1:0];
  assign err_sticky  = sticky_q;
  assign err_count   = count_q;
  assign first_valid = first_valid_q;
  assign first_mask  = first_mask_q;
  assign first_cyc   = first_cyc_q;
  assign log_ovf     = ovf_q;

endmodule
